// File: rtl/alu_rs.sv
// alu_rs: reservation station feeding the integer ALU; captures operands from ALU/LSB broadcasts
// and issues the lowest-index operand-complete entry each cycle through registered outputs.
module alu_rs #(
  parameter int RS_SIZE        = 8,
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      dec_valid,
  input  logic [ALU_OP_WIDTH-1:0]   dec_op,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_id,
  input  logic                      dec_dep1,
  input  logic                      dec_dep2,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_tag1,
  input  logic [ROB_SIZE_WIDTH-1:0] dec_tag2,
  input  logic [XLEN-1:0]           dec_val1,
  input  logic [XLEN-1:0]           dec_val2,
  output logic                      rs_full,
  input  logic                      alu_ready,
  input  logic [XLEN-1:0]           alu_res,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
  input  logic                      lsb_ready,
  input  logic [XLEN-1:0]           lsb_res,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_id,
  output logic                      rs_ready,
  output logic [ALU_OP_WIDTH-1:0]   rs_op,
  output logic [XLEN-1:0]           rs_val1,
  output logic [XLEN-1:0]           rs_val2,
  output logic [ROB_SIZE_WIDTH-1:0] rs_id
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0]        busy_q, dep1_q, dep2_q, cand;
  logic [ALU_OP_WIDTH-1:0]   op_q   [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] id_q   [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] tag1_q [RS_SIZE];
  logic [ROB_SIZE_WIDTH-1:0] tag2_q [RS_SIZE];
  logic [XLEN-1:0]           val1_q [RS_SIZE];
  logic [XLEN-1:0]           val2_q [RS_SIZE];
  logic [IW-1:0]             free_idx, iss_idx;
  logic                      has_cand, disp;
  // ALU broadcast takes precedence when both buses carry the awaited tag
  function automatic logic [XLEN:0] snoop(input logic dep, input logic [ROB_SIZE_WIDTH-1:0] tag,
                                          input logic [XLEN-1:0] val);
    snoop = (dep && alu_ready && alu_id == tag) ? {1'b0, alu_res} :
            (dep && lsb_ready && lsb_id == tag) ? {1'b0, lsb_res} : {dep, val};
  endfunction
  assign rs_full  = &busy_q;
  assign cand     = busy_q & ~dep1_q & ~dep2_q;
  assign has_cand = |cand;
  assign disp     = dec_valid & ~rs_full;
  always_comb begin
    free_idx = '0;
    iss_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IW'(i);
      if (cand[i]) iss_idx = IW'(i);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      rs_ready <= 1'b0;
      rs_op    <= '0;
      rs_val1  <= '0;
      rs_val2  <= '0;
      rs_id    <= '0;
    end else if (flush) begin
      busy_q   <= '0;
      rs_ready <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy_q[i]) begin
          {dep1_q[i], val1_q[i]} <= snoop(dep1_q[i], tag1_q[i], val1_q[i]);
          {dep2_q[i], val2_q[i]} <= snoop(dep2_q[i], tag2_q[i], val2_q[i]);
        end
      end
      rs_ready <= has_cand;
      if (has_cand) begin
        rs_op            <= op_q[iss_idx];
        rs_val1          <= val1_q[iss_idx];
        rs_val2          <= val2_q[iss_idx];
        rs_id            <= id_q[iss_idx];
        busy_q[iss_idx]  <= 1'b0;
      end
      // target is free at cycle start, so it never collides with issue or wakeup
      if (disp) begin
        busy_q[free_idx]                     <= 1'b1;
        op_q[free_idx]                       <= dec_op;
        id_q[free_idx]                       <= dec_id;
        tag1_q[free_idx]                     <= dec_tag1;
        tag2_q[free_idx]                     <= dec_tag2;
        {dep1_q[free_idx], val1_q[free_idx]} <= snoop(dec_dep1, dec_tag1, dec_val1);
        {dep2_q[free_idx], val2_q[free_idx]} <= snoop(dec_dep2, dec_tag2, dec_val2);
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus a randomized run against an entry-list reference model.
module tb_alu_rs;
  logic        clk = 0, rst = 0, flush = 0;
  logic        dec_valid, dec_dep1, dec_dep2, alu_ready, lsb_ready;
  logic [3:0]  dec_op, dec_id, dec_tag1, dec_tag2, alu_id, lsb_id;
  logic [31:0] dec_val1, dec_val2, alu_res, lsb_res;
  logic        rs_full, rs_ready;
  logic [3:0]  rs_op, rs_id;
  logic [31:0] rs_val1, rs_val2;
  int checks = 0, errors = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_op(dec_op), .dec_id(dec_id),
    .dec_dep1(dec_dep1), .dec_dep2(dec_dep2), .dec_tag1(dec_tag1), .dec_tag2(dec_tag2),
    .dec_val1(dec_val1), .dec_val2(dec_val2), .rs_full(rs_full), .alu_ready(alu_ready),
    .alu_res(alu_res), .alu_id(alu_id), .lsb_ready(lsb_ready), .lsb_res(lsb_res), .lsb_id(lsb_id),
    .rs_ready(rs_ready), .rs_op(rs_op), .rs_val1(rs_val1), .rs_val2(rs_val2), .rs_id(rs_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy; logic [3:0] op, id; bit d1, d2; logic [3:0] t1, t2; logic [31:0] v1, v2;
  } ent_t;
  ent_t m[8];
  bit m_rdy;
  logic [3:0] m_op, m_id;
  logic [31:0] m_v1, m_v2;

  task automatic step; @(posedge clk); #1; endtask

  task automatic clr_in;
    dec_valid = 0; dec_op = 0; dec_id = 0; dec_dep1 = 0; dec_dep2 = 0; dec_tag1 = 0; dec_tag2 = 0;
    dec_val1 = 0; dec_val2 = 0; alu_ready = 0; alu_res = 0; alu_id = 0;
    lsb_ready = 0; lsb_res = 0; lsb_id = 0; flush = 0; rst = 0;
  endtask

  task automatic set_dec(input logic [3:0] op, id, input logic d1, input logic [3:0] t1,
                         input logic [31:0] v1, input logic d2, input logic [3:0] t2, input logic [31:0] v2);
    dec_valid = 1; dec_op = op; dec_id = id; dec_dep1 = d1; dec_tag1 = t1; dec_val1 = v1;
    dec_dep2 = d2; dec_tag2 = t2; dec_val2 = v2;
  endtask

  // operand resolution: a pending operand takes the ALU result, else the load result, on tag match
  function automatic logic [32:0] resolve(input bit d, input logic [3:0] t, input logic [31:0] v);
    if (d && alu_ready && alu_id == t) return {1'b0, alu_res};
    if (d && lsb_ready && lsb_id == t) return {1'b0, lsb_res};
    return {d, v};
  endfunction

  function automatic bit m_full;
    m_full = 1;
    foreach (m[i]) if (!m[i].busy) m_full = 0;
  endfunction

  task automatic model_step;
    int iss, fr;
    ent_t nx[8];
    if (rst) begin
      foreach (m[i]) m[i].busy = 0;
      m_rdy = 0; m_op = 0; m_id = 0; m_v1 = 0; m_v2 = 0;
      return;
    end
    if (flush) begin
      foreach (m[i]) m[i].busy = 0;
      m_rdy = 0;
      return;
    end
    iss = -1; fr = -1;
    for (int i = 7; i >= 0; i--) begin
      if (m[i].busy && !m[i].d1 && !m[i].d2) iss = i;
      if (!m[i].busy) fr = i;
    end
    nx = m;
    foreach (m[i]) if (m[i].busy) begin
      {nx[i].d1, nx[i].v1} = resolve(m[i].d1, m[i].t1, m[i].v1);
      {nx[i].d2, nx[i].v2} = resolve(m[i].d2, m[i].t2, m[i].v2);
    end
    m_rdy = (iss >= 0);
    if (iss >= 0) begin
      m_op = m[iss].op; m_id = m[iss].id; m_v1 = m[iss].v1; m_v2 = m[iss].v2;
      nx[iss].busy = 0;
    end
    if (dec_valid && fr >= 0) begin
      nx[fr].busy = 1; nx[fr].op = dec_op; nx[fr].id = dec_id;
      nx[fr].t1 = dec_tag1; nx[fr].t2 = dec_tag2;
      {nx[fr].d1, nx[fr].v1} = resolve(dec_dep1, dec_tag1, dec_val1);
      {nx[fr].d2, nx[fr].v2} = resolve(dec_dep2, dec_tag2, dec_val2);
    end
    m = nx;
  endtask

  task automatic test_reset;
    clr_in; rst = 1; step; rst = 0;
    checks++; if ({rs_ready, rs_op, rs_id, rs_val1, rs_val2} !== 73'd0) begin errors++;
      $display("FAIL reset_outputs got %b/%h/%h/%h/%h exp all zero", rs_ready, rs_op, rs_id, rs_val1, rs_val2); end
    checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", rs_full); end
  endtask

  task automatic test_latency;
    set_dec(4'd0, 4'd3, 0, 0, 32'd5, 0, 0, 32'd7); step; clr_in;
    checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL lat_early rs_ready got %b exp 0", rs_ready); end
    step;
    checks++; if ({rs_ready, rs_op, rs_id, rs_val1, rs_val2} !== {1'b1, 4'd0, 4'd3, 32'd5, 32'd7}) begin errors++;
      $display("FAIL lat_issue got %b/%h/%h/%h/%h exp 1/0/3/5/7", rs_ready, rs_op, rs_id, rs_val1, rs_val2); end
    step;
    checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL lat_pulse rs_ready got %b exp 0", rs_ready); end
  endtask

  task automatic test_wakeup(input bit use_lsb);
    logic [31:0] exp_v;
    exp_v = use_lsb ? 32'hFFFF_FFFF : 32'h10;
    set_dec(4'd3, 4'd2, 1, 4'd6, 0, 0, 0, 32'd3); step; clr_in;
    repeat (4) begin
      step;
      checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL wake_hold rs_ready got %b exp 0", rs_ready); end
    end
    if (use_lsb) begin lsb_ready = 1; lsb_id = 6; lsb_res = exp_v; end
    else begin alu_ready = 1; alu_id = 6; alu_res = exp_v; end
    step; clr_in;
    checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL wake_early rs_ready got %b exp 0", rs_ready); end
    step;
    checks++; if ({rs_ready, rs_op, rs_id, rs_val1, rs_val2} !== {1'b1, 4'd3, 4'd2, exp_v, 32'd3}) begin errors++;
      $display("FAIL wake_issue lsb=%0d got %b/%h/%h/%h/%h exp 1/3/2/%h/3", use_lsb, rs_ready, rs_op, rs_id, rs_val1, rs_val2, exp_v); end
    step;
  endtask

  task automatic test_bypass;
    set_dec(4'd5, 4'd7, 0, 0, 32'd11, 1, 4'd5, 0);
    lsb_ready = 1; lsb_id = 5; lsb_res = 32'd9; step; clr_in;
    checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL byp_early rs_ready got %b exp 0", rs_ready); end
    step;
    checks++; if ({rs_ready, rs_id, rs_val1, rs_val2} !== {1'b1, 4'd7, 32'd11, 32'd9}) begin errors++;
      $display("FAIL byp_issue got %b/%h/%h/%h exp 1/7/b/9", rs_ready, rs_id, rs_val1, rs_val2); end
    step;
  endtask

  task automatic test_full;
    bit quiet = 1;
    for (int i = 0; i < 8; i++) begin
      set_dec(4'd1, 4'(i), 1, 4'(8 + i), 0, 0, 0, 32'(i * 100)); step;
      if (rs_ready !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL full_fill issued while pending got 1 exp 0"); end
    checks++; if (rs_full !== 1'b1) begin errors++; $display("FAIL full_set got %b exp 1", rs_full); end
    set_dec(4'd2, 4'd9, 0, 0, 32'd1, 0, 0, 32'd2); step; clr_in; step; step;
    checks++; if ({rs_full, rs_ready} !== 2'b10) begin errors++;
      $display("FAIL full_drop full/ready got %b/%b exp 1/0", rs_full, rs_ready); end
    alu_ready = 1; alu_id = 12; alu_res = 32'h44; step; clr_in;
    checks++; if ({rs_full, rs_ready} !== 2'b10) begin errors++;
      $display("FAIL full_wake full/ready got %b/%b exp 1/0", rs_full, rs_ready); end
    step;
    checks++; if ({rs_ready, rs_id, rs_val1, rs_val2, rs_full} !== {1'b1, 4'd4, 32'h44, 32'd400, 1'b0}) begin errors++;
      $display("FAIL full_issue got %b/%h/%h/%h full %b exp 1/4/44/190 full 0", rs_ready, rs_id, rs_val1, rs_val2, rs_full); end
    set_dec(4'd3, 4'd13, 0, 0, 32'd1, 0, 0, 32'd2); step; clr_in;
    checks++; if ({rs_full, rs_ready} !== 2'b10) begin errors++;
      $display("FAIL full_refill full/ready got %b/%b exp 1/0", rs_full, rs_ready); end
    step;
    checks++; if ({rs_ready, rs_id, rs_full} !== {1'b1, 4'd13, 1'b0}) begin errors++;
      $display("FAIL full_reissue got %b/%h full %b exp 1/d full 0", rs_ready, rs_id, rs_full); end
    flush = 1; step; clr_in;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      set_dec(4'd6, 4'(i), 1, (i == 1 || i == 5) ? 4'd2 : 4'd1, 0, 0, 0, 32'(i)); step;
    end
    clr_in; alu_ready = 1; alu_id = 2; alu_res = 32'h22; step; clr_in; step;
    checks++; if ({rs_ready, rs_id, rs_val1, rs_val2} !== {1'b1, 4'd1, 32'h22, 32'd1}) begin errors++;
      $display("FAIL b2b_first got %b/%h/%h/%h exp 1/1/22/1", rs_ready, rs_id, rs_val1, rs_val2); end
    step;
    checks++; if ({rs_ready, rs_id, rs_val1, rs_val2} !== {1'b1, 4'd5, 32'h22, 32'd5}) begin errors++;
      $display("FAIL b2b_second got %b/%h/%h/%h exp 1/5/22/5", rs_ready, rs_id, rs_val1, rs_val2); end
    step;
    checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL b2b_end rs_ready got %b exp 0", rs_ready); end
    flush = 1; step; clr_in;
  endtask

  task automatic test_flush(input bit use_rst);
    bit quiet = 1;
    for (int i = 0; i < 3; i++) begin set_dec(4'd2, 4'(i), 1, 4'd1, 0, 0, 0, 0); step; end
    clr_in; alu_ready = 1; alu_id = 1; alu_res = 32'd7; step; clr_in;
    set_dec(4'd4, 4'd10, 0, 0, 32'd1, 0, 0, 32'd1);
    if (use_rst) rst = 1; else flush = 1;
    step; clr_in;
    checks++; if ({rs_ready, rs_full} !== 2'b00) begin errors++;
      $display("FAIL flush_now rst=%0d ready/full got %b/%b exp 0/0", use_rst, rs_ready, rs_full); end
    repeat (6) begin step; if (rs_ready !== 1'b0) quiet = 0; end
    checks++; if (!quiet) begin errors++; $display("FAIL flush_quiet rst=%0d issued got 1 exp 0", use_rst); end
  endtask

  task automatic test_random;
    clr_in; rst = 1; model_step; step;
    for (int c = 0; c < 600; c++) begin
      clr_in;
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      dec_valid = $urandom_range(0, 1); dec_op = 4'($urandom); dec_id = 4'($urandom);
      dec_dep1 = $urandom_range(0, 1); dec_dep2 = $urandom_range(0, 1);
      dec_tag1 = 4'($urandom_range(0, 3)); dec_tag2 = 4'($urandom_range(0, 3));
      dec_val1 = $urandom; dec_val2 = $urandom;
      alu_ready = $urandom_range(0, 1); alu_id = 4'($urandom_range(0, 3)); alu_res = $urandom;
      lsb_ready = $urandom_range(0, 1); lsb_id = 4'($urandom_range(0, 3)); lsb_res = $urandom;
      model_step; step;
      checks++; if (rs_full !== m_full()) begin errors++;
        $display("FAIL rand_full cyc %0d got %b exp %b", c, rs_full, m_full()); end
      checks++; if ({rs_ready, rs_op, rs_id, rs_val1, rs_val2} !== {m_rdy, m_op, m_id, m_v1, m_v2}) begin errors++;
        $display("FAIL rand_out cyc %0d got %b/%h/%h/%h/%h exp %b/%h/%h/%h/%h", c,
                 rs_ready, rs_op, rs_id, rs_val1, rs_val2, m_rdy, m_op, m_id, m_v1, m_v2); end
    end
    clr_in;
  endtask

  initial begin
    clr_in;
    test_reset;
    test_latency;
    test_wakeup(0);
    test_wakeup(1);
    test_bypass;
    test_full;
    test_back_to_back;
    test_flush(0);
    test_flush(1);
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station directly upstream of the integer ALU.
- Accepts decoded ALU/branch-compare ops with operand values or ROB tags, and captures missing operands from the ALU and LSB result broadcasts.
- Issues at most one operand-complete entry per cycle to the ALU through a registered interface.
- Purges all contents on a mispredict flush.

Parameters:
RS_SIZE, 8, number of entries (power of two, >=2)
XLEN, 32, data width
ROB_SIZE_WIDTH, 4, ROB tag width
ALU_OP_WIDTH, 4, ALU opcode width (same encoding the ALU consumes)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  mispredict flush; discards all entries
dec_valid  in  1  dispatch request this cycle
dec_op  in  ALU_OP_WIDTH  operation
dec_id  in  ROB_SIZE_WIDTH  ROB id of instruction
dec_dep1 / dec_dep2  in  1  operand n still pending (value not yet available)
dec_tag1 / dec_tag2  in  ROB_SIZE_WIDTH  ROB id producing operand n (valid when dep set)
dec_val1 / dec_val2  in  XLEN  operand n value (valid when dep clear)
rs_full  out  1  all entries busy; combinational from busy bits
alu_ready  in  1  ALU result broadcast valid
alu_res  in  XLEN  ALU result
alu_id  in  ROB_SIZE_WIDTH  ROB id of ALU result
lsb_ready  in  1  load result broadcast valid
lsb_res  in  XLEN  load result
lsb_id  in  ROB_SIZE_WIDTH  ROB id of load result
rs_ready  out  1  issue valid to ALU (registered)
rs_op  out  ALU_OP_WIDTH  issued op (registered)
rs_val1 / rs_val2  out  XLEN  issued operands (registered)
rs_id  out  ROB_SIZE_WIDTH  issued ROB id (registered)

Behaviour:
- Reset: rst is synchronous, active-high, and has priority over flush. On reset:
  - all busy bits clear;
  - rs_ready=0, rs_op=0, rs_val1=0, rs_val2=0, rs_id=0;
  - rs_full=0 from the following cycle.
- Per entry, the following fields are kept:
  - busy, op, id;
  - dep1/dep2, tag1/tag2, val1/val2.
- Dispatch:
  - Condition: dec_valid && !rs_full && !flush && !rst.
  - Target: the lowest-index entry not busy at the start of the cycle.
  - If dec_validwith rs_full=1, the request is ignored and no state changes. The decoder must stall on rs_full.
  - Same-cycle bypass: if dec_depN && alu_ready && alu_id==dec_tagN, store alu_res with depN=0. Else if dec_depN && lsb_ready && lsb_id==dec_tagN, store lsb_res with depN=0.
- Wakeup, every cycle, for each busy entry and each operand with depN=1:
  - if alu_ready && alu_id==tagN: valN<=alu_res, depN<=0;
  - else if lsb_ready && lsb_id==tagN: valN<=lsb_res, depN<=0.
  - ALU broadcast wins if both match (protocol violation, but deterministic).
- Issue selection:
  - Candidates are entries with busy && !dep1 && !dep2 as registered at the start of the cycle. Operands woken this cycle become eligible next cycle.
  - The lowest-index candidate is chosen.
  - On the next edge: rs_ready<=1, rs_op/rs_val1/rs_val2/rs_id <= the entry fields, and the entry's busy bit <=0.
  - No candidate: rs_ready<=0, and the other outputs hold their values.
  - The ALU never back-pressures, so an issue always succeeds.
- Dispatch and issue in the same cycle are allowed:
  - The dispatch target is chosen from start-of-cycle free entries.
  - An entry freed by issue is reusable from the next cycle.
  - rs_full deasserts the cycle after the issue.
- Latency, dispatch with both operands ready at cycle N:
  - entry valid after edge N;
  - selected in N+1;
  - rs_ready=1 during N+2;
  - ALU result valid during N+3.
- Flush (when rst=0):
  - all busy bits <=0 and rs_ready<=0 on the same edge;
  - any concurrent dispatch and issue are discarded;
  - wakeups that cycle are ignored.
- Tags and values are compared and stored exactly; no arithmetic is performed in this block.

Test Plan:
- After rst, dispatch op=ADD, id=3, val1=5, val2=7, no deps → rs_ready=1 exactly 2 cycles later with rs_op=ADD, rs_val1=5, rs_val2=7, rs_id=3; one cycle pulse only.
- Dispatch id=2 with dep1 on tag 6; hold 4 cycles, then alu_ready=1, alu_id=6, alu_res=0x10 → issue 2 cycles after broadcast with rs_val1=0x10. Repeat via lsb_id=6, lsb_res=0xFFFFFFFF.
- Dispatch with dep2 tag 5 in the same cycle as lsb broadcast id 5, res 9 (bypass) → entry issues as fully ready, rs_val2=9, at dispatch+2.
- Fill all 8 entries with pending deps → rs_full=1; a 9th dispatch is dropped. Wake entry 4 → it issues; rs_full drops the cycle after issue; a new dispatch lands in entry 4.
- Two entries ready simultaneously (idx 1 and 5) → idx 1 issues first, idx 5 the next cycle, rs_ready high both cycles.
- 3 entries busy, rs_ready about to assert; assert flush with concurrent dec_valid → next cycle rs_ready=0, rs_full=0, no issues ever. Same sequence with rst instead gives an identical result.
